arb_mux_reg: RTL

- Registered successor to the combinational configurable mux.
- Selects one of 2**nb_bits_select valid/ready input channels and forwards the chosen word through a single output register with a valid/ready handshake.
- Selection is by external index, fixed priority or round-robin, chosen at run time by mode_i.
- Used between multi-source producers (e.g. writeback sources, memory request ports) and a single consumer that can stall.

---
 rtl/arb_mux_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/arb_mux_reg.sv
// Registered N-way valid/ready mux: external-select, fixed-priority or round-robin arbitration
// into a single output register. Optional transfer counter: define ARB_MUX_REG_STATS_EN.
module arb_mux_reg #(
   parameter int unsigned nb_bits_select        = 2,
   parameter int unsigned nb_bits_taille_donnes = 32
) (
   input  logic                                                     clk_i,
   input  logic                                                     rst_i,
   input  logic [(2**nb_bits_select)-1:0][nb_bits_taille_donnes-1:0] data_i,
   input  logic [(2**nb_bits_select)-1:0]                           valid_i,
   output logic [(2**nb_bits_select)-1:0]                           ready_o,
   input  logic [1:0]                                               mode_i,
   input  logic [nb_bits_select-1:0]                                sel_i,
   output logic [nb_bits_taille_donnes-1:0]                         data_o,
   output logic                                                     valid_o,
   input  logic                                                     ready_i,
   output logic [nb_bits_select-1:0]                                grant_o
`ifdef ARB_MUX_REG_STATS_EN
   ,
   output logic [31:0]                                              xfer_cnt_o
`endif
);

   localparam int unsigned N  = 2**nb_bits_select;
   localparam int unsigned SW = nb_bits_select;
   localparam int unsigned DW = nb_bits_taille_donnes;

   localparam logic [1:0] MODE_EXT = 2'b00;
   localparam logic [1:0] MODE_RR  = 2'b10;

   logic [DW-1:0] r_data;
   logic          r_valid;
   logic [SW-1:0] r_grant;
   logic [SW-1:0] r_rr_ptr;

   logic          w_load_en;
   logic          w_found;
   logic [SW-1:0] w_cand;
   logic [SW-1:0] w_idx;

   // Output register can take a new word when empty or being drained this cycle
   assign w_load_en = !r_valid || ready_i;

   // Candidate selection; mode 11 falls through to fixed priority
   always_comb begin
      w_found = 1'b0;
      w_cand  = '0;
      w_idx   = '0;
      case (mode_i)
         MODE_EXT: begin
            if (valid_i[sel_i]) begin
               w_found = 1'b1;
               w_cand  = sel_i;
            end
         end
         MODE_RR: begin
            for (int unsigned i = 0; i < N; i++) begin
               w_idx = r_rr_ptr + SW'(i);
               if (!w_found && valid_i[w_idx]) begin
                  w_found = 1'b1;
                  w_cand  = w_idx;
               end
            end
         end
         default: begin
            for (int unsigned i = 0; i < N; i++) begin
               if (!w_found && valid_i[SW'(i)]) begin
                  w_found = 1'b1;
                  w_cand  = SW'(i);
               end
            end
         end
      endcase
   end

   assign ready_o = (w_load_en && w_found && !rst_i) ? (N'(1) << w_cand) : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else if (w_load_en) begin
         if (w_found) begin
            r_data  <= data_i[w_cand];
            r_grant <= w_cand;
            r_valid <= 1'b1;
            if (mode_i == MODE_RR) begin
               r_rr_ptr <= w_cand + SW'(1);
            end
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign grant_o = r_grant;

`ifdef ARB_MUX_REG_STATS_EN
   logic [31:0] r_xfer_cnt;

   // Saturating count of output handshakes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_xfer_cnt <= '0;
      end else if (r_valid && ready_i && (r_xfer_cnt != 32'hFFFF_FFFF)) begin
         r_xfer_cnt <= r_xfer_cnt + 32'd1;
      end
   end

   assign xfer_cnt_o = r_xfer_cnt;
`else
   // Statistics counter not built
`endif

endmodule
